vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//   Pixel-rate VGA raster timing generator and output stage for the ball-game display.
//   Drives the raster coordinates oVGA_X/oVGA_Y into the page colour generators
//   (start, game and game-over pages), which are combinational.
//   Registers the selected 1-bit R/G/B back in, masks it with blanking and
//   re-aligns it with HS/VS/BLANK_N for the DAC/connector.
// PARAMETERS
//   H_VISIBLE  640  active pixels per line
//   H_FRONT    16   horizontal front porch, pixels
//   H_SYNC     96   horizontal sync width, pixels
//   H_BACK     48   horizontal back porch, pixels (H_TOTAL = sum = 800)
//   V_VISIBLE  480  active lines per frame
//   V_FRONT    10   vertical front porch, lines
//   V_SYNC     2    vertical sync width, lines
//   V_BACK     33   vertical back porch, lines (V_TOTAL = sum = 525)
//   HS_POL     0    asserted level of oVGA_HS
//   VS_POL     0    asserted level of oVGA_VS
// PORTS
//   iCLK         in   1   25 MHz pixel clock; the only clock
//   iRST         in   1   synchronous reset, active-high
//   iVGA_R       in   1   red from the page colour generator, for the current oVGA_X/oVGA_Y
//   iVGA_G       in   1   green, same timing as iVGA_R
//   iVGA_B       in   1   blue, same timing as iVGA_R
//   oVGA_X       out  11  raster column, 0..H_TOTAL-1
//   oVGA_Y       out  10  raster line, 0..V_TOTAL-1
//   oFRAME_START out  1   one-cycle pulse while oVGA_X==0 and oVGA_Y==0
//   oVGA_HS      out  1   horizontal sync
//   oVGA_VS      out  1   vertical sync
//   oVGA_BLANK_N out  1   1 = active video
//   oVGA_R       out  1   red to DAC
//   oVGA_G       out  1   green to DAC
//   oVGA_B       out  1   blue to DAC
// BEHAVIOUR
//   Stage 0: counters h_cnt, v_cnt
//   - h_cnt counts 0..H_TOTAL-1 and wraps to 0.
//   - v_cnt increments when h_cnt wraps; v_cnt wraps to 0 when h_cnt wraps and v_cnt==V_TOTAL-1.
//   Stage 1: registered from stage 0
//   - oVGA_X = h_cnt, oVGA_Y = v_cnt (full raster range; no clamping).
//   - act1 = (h_cnt<H_VISIBLE) && (v_cnt<V_VISIBLE).
//   - hs1 asserted for h_cnt in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. 656..751.
//   - vs1 asserted for v_cnt in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], i.e. 490..491.
//   - oFRAME_START = (h_cnt==0 && v_cnt==0).
//   Stage 2: registered from stage 1
//   - oVGA_HS = hs1 ? HS_POL : ~HS_POL; oVGA_VS likewise with VS_POL.
//   - oVGA_BLANK_N = act1.
//   - oVGA_{R,G,B} = act1 ? iVGA_{R,G,B} : 0.
//   - Colour is therefore sampled 1 cycle after its coordinate; sync, blank and RGB are
//     mutually aligned, and lag oVGA_X/oVGA_Y by exactly 1 cycle.
//   Reset (iRST high at an edge, including mid-frame):
//   - h_cnt=v_cnt=0, oVGA_X=0, oVGA_Y=0, act1=0, hs1=vs1=0, oFRAME_START=0,
//     oVGA_BLANK_N=0, RGB=0, HS=~HS_POL, VS=~VS_POL.
//   - First edge with iRST low: oVGA_X=0, oVGA_Y=0, oFRAME_START=1 (new frame starts cleanly).
//   - No partial line or frame is emitted after reset.
//   Widths: the 11-bit X and 10-bit Y hold H_TOTAL-1 and V_TOTAL-1 without overflow.
// TESTING
//   1 Reset 5 cycles, release -> next edge X=0,Y=0,FRAME_START=1; following edge BLANK_N=1, HS/VS deasserted.
//   2 Run 1 line -> BLANK_N high 640 cycles, low 16, HS low 96, high 48; line period 800 cycles.
//   3 Run 2 frames -> VS low exactly 1600 cycles starting at line 490; FRAME_START once per 420000 cycles.
//   4 Tie iVGA_R=iVGA_G=iVGA_B=1 -> RGB equals BLANK_N every cycle; all 0 during porches and sync.
//   5 Drive iVGA_R=(oVGA_X==231 && oVGA_Y==240) -> oVGA_R high 1 cycle per frame, the 232nd BLANK_N cycle of line 240.
//   6 Assert iRST 1 cycle at v_cnt=300, h_cnt=400 -> next edge all reset values; then restart at (0,0) with FRAME_START.

Source files
------------

// File: rtl/vga_timing_if.sv
// Raster bundle between the VGA timing generator, the page colour generators and the DAC.
// The master drives coordinates, sync and colour out, and takes colour back in.
interface vga_timing_if;
   logic        iVGA_R;
   logic        iVGA_G;
   logic        iVGA_B;
   logic [10:0] oVGA_X;
   logic [9:0]  oVGA_Y;
   logic        oFRAME_START;
   logic        oVGA_HS;
   logic        oVGA_VS;
   logic        oVGA_BLANK_N;
   logic        oVGA_R;
   logic        oVGA_G;
   logic        oVGA_B;

   modport master (
      input  iVGA_R, iVGA_G, iVGA_B,
      output oVGA_X, oVGA_Y, oFRAME_START, oVGA_HS, oVGA_VS,
      output oVGA_BLANK_N, oVGA_R, oVGA_G, oVGA_B
   );

   modport slave (
      output iVGA_R, iVGA_G, iVGA_B,
      input  oVGA_X, oVGA_Y, oFRAME_START, oVGA_HS, oVGA_VS,
      input  oVGA_BLANK_N, oVGA_R, oVGA_G, oVGA_B
   );
endinterface

// File: rtl/vga_timing_gen.sv
// Pixel-rate VGA raster generator: counters, registered coordinates/sync, and an output
// stage that masks the returned colour with blanking and aligns it with HS/VS/BLANK_N.
module vga_timing_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter bit HS_POL    = 1'b0,
   parameter bit VS_POL    = 1'b0
) (
   input  logic          iCLK,
   input  logic          iRST,
   vga_timing_if.master  vga
);
   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [10:0] H_ACT_END  = 11'(H_VISIBLE);
   localparam logic [9:0]  V_ACT_END  = 10'(V_VISIBLE);
   localparam logic [10:0] HS_FIRST   = 11'(H_VISIBLE + H_FRONT);
   localparam logic [10:0] HS_LAST    = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0]  VS_FIRST   = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0]  VS_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   logic [10:0] r_h_cnt;
   logic [9:0]  r_v_cnt;
   logic        w_h_wrap;

   logic [10:0] r_x;
   logic [9:0]  r_y;
   logic        r_act1;
   logic        r_hs1;
   logic        r_vs1;
   logic        r_frame_start;

   logic        r_hs;
   logic        r_vs;
   logic        r_blank_n;
   logic [2:0]  r_rgb;
   logic [2:0]  w_rgb_in;

   assign w_h_wrap = (r_h_cnt == H_LAST);
   assign w_rgb_in = {vga.iVGA_R, vga.iVGA_G, vga.iVGA_B};

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else begin
         r_h_cnt <= w_h_wrap ? 11'd0 : r_h_cnt + 11'd1;
         if (w_h_wrap)
            r_v_cnt <= (r_v_cnt == V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
      end
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         r_x           <= '0;
         r_y           <= '0;
         r_act1        <= 1'b0;
         r_hs1         <= 1'b0;
         r_vs1         <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_x           <= r_h_cnt;
         r_y           <= r_v_cnt;
         r_act1        <= (r_h_cnt < H_ACT_END) && (r_v_cnt < V_ACT_END);
         r_hs1         <= (r_h_cnt >= HS_FIRST) && (r_h_cnt <= HS_LAST);
         r_vs1         <= (r_v_cnt >= VS_FIRST) && (r_v_cnt <= VS_LAST);
         r_frame_start <= (r_h_cnt == 11'd0) && (r_v_cnt == 10'd0);
      end
   end

   // Colour returned for the stage-1 coordinate lands in the same stage as its sync/blank.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         r_hs      <= ~HS_POL;
         r_vs      <= ~VS_POL;
         r_blank_n <= 1'b0;
      end else begin
         r_hs      <= r_hs1 ? HS_POL : ~HS_POL;
         r_vs      <= r_vs1 ? VS_POL : ~VS_POL;
         r_blank_n <= r_act1;
      end
   end

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_rgb
         always_ff @(posedge iCLK) begin
            if (iRST)
               r_rgb[gi] <= 1'b0;
            else
               r_rgb[gi] <= r_act1 & w_rgb_in[gi];
         end
      end
   endgenerate

   assign vga.oVGA_X       = r_x;
   assign vga.oVGA_Y       = r_y;
   assign vga.oFRAME_START = r_frame_start;
   assign vga.oVGA_HS      = r_hs;
   assign vga.oVGA_VS      = r_vs;
   assign vga.oVGA_BLANK_N = r_blank_n;
   assign vga.oVGA_R       = r_rgb[2];
   assign vga.oVGA_G       = r_rgb[1];
   assign vga.oVGA_B       = r_rgb[0];
endmodule
